key_event_scheduler: RTL and testbench
======================================

// Module: key_event_scheduler
// PURPOSE
// Per-key press/release controller for N debounced keys on the 100 Hz domain.
// - Classifies each key press as SHORT (released before LONG_TICKS) or LONG (held LONG_TICKS).
// - Shares a single event FIFO between all keys using round-robin arbitration.
// - Feeds the menu/mode FSM through a valid/ready handshake.
// - Replaces the scattered per-key edge pulses with one ordered event stream.
// PARAMETERS
// N_KEYS      5    number of debounced key inputs
// IDX_W       3    width of key index, must satisfy 2^IDX_W >= N_KEYS
// LONG_TICKS  100  consecutive high samples that form a LONG press (1 s at 100 Hz), >= 2
// FIFO_DEPTH  4    event FIFO entries, power of two
// PORTS
// clk_100Hz   in   1       100 Hz system tick clock
// rst_n       in   1       asynchronous, active-low reset
// key_in      in   N_KEYS  debounced key levels, 1 = pressed
// evt_valid   out  1       FIFO head holds an event
// evt_ready   in   1       consumer accepts the head this cycle
// evt_key     out  IDX_W   key index of the head event
// evt_long    out  1       1 = LONG event, 0 = SHORT event
// overflow    out  1       1-cycle pulse: an event was dropped
// busy        out  1       any pending request OR FIFO not empty
// BEHAVIOUR
// - Reset values: all outputs 0; key_dly, pending, rr_ptr, counters, FIFO pointers 0; all keys IDLE.
// - Key registered: key_dly <= key_in each edge. Press = ~key_dly & key_in. Release = key_dly & ~key_in.
// - Per-key FSM:
//   - IDLE -> PRESSED on press; cnt <= 1.
//   - PRESSED: while key_in=1, cnt++. On the edge where cnt would reach LONG_TICKS, raise a LONG
//     request and go to LONG_HELD. On release, raise a SHORT request and go to IDLE.
//   - LONG_HELD -> IDLE on release, with no event.
//   - cnt width = $clog2(LONG_TICKS+1). cnt saturates and never wraps.
// - Request rules:
//   - A raised request sets pending[i] and stores the type in pend_long[i] on that edge.
//   - If pending[i] is already 1, the new request is dropped, the old one is kept, and overflow
//     pulses high for 1 cycle.
// - Arbiter:
//   - Each edge, if any pending and (FIFO not full OR pop this cycle), grant the first pending
//     index scanning cyclically from rr_ptr.
//   - Push {idx, pend_long[idx]}, clear pending[idx], set rr_ptr <= (idx+1) mod N_KEYS.
//   - At most one push per cycle.
// - FIFO full with no pop: requests stay pending; no loss and no overflow.
// - A request raised on the same edge as its key's grant is not lost: clear and set give set
//   priority.
// - Handshake and outputs:
//   - Pop when evt_valid & evt_ready.
//   - evt_key and evt_long show the head entry and are stable while evt_valid=1 and evt_ready=0.
//   - Simultaneous push and pop on a full FIFO are allowed.
// - Latency: the release is sampled at edge E0 and pending is set at E0. With the FIFO empty and
//   no competitors, the push occurs at E1 and evt_valid=1 after E1.
// - Reset mid-operation clears everything, including queued events. A key still held when reset
//   deasserts is seen as a fresh press at the first edge (key_dly=0), and LONG fires LONG_TICKS
//   later.
// TESTING
// 1. Key 2 high for 10 edges, then low; ready=1
//    -> evt_valid 1 cycle after pending, evt_key=2, evt_long=0, popped next edge, busy returns 0.
// 2. Key 0 held 150 edges
//    -> LONG event (key 0, evt_long=1) at the 100th high sample; no event on release.
// 3. Keys 1 and 3 release on the same edge, rr_ptr=0
//    -> events delivered in order 1, 3 (rr_ptr=4).
//    Then keys 0 and 4 release together -> events delivered in order 4, 0.
// 4. ready=0; SHORT releases on keys 0..4 on distinct edges
//    -> FIFO holds 0,1,2,3; key 4 stays pending; busy=1; overflow=0.
//    Then ready=1 -> events 0,1,2,3,4 delivered in order.
// 5. FIFO full, key 1 pending, key 1 pressed and released again
//    -> overflow=1 for exactly 1 cycle; only one key-1 event delivered.
// 6. rst_n pulsed low during a 60-edge hold of key 3, with key 3 still high after reset
//    -> all outputs 0 during reset; LONG event for key 3 delivered LONG_TICKS edges after release.

Source files
------------

// File: rtl/key_event_if.sv
// Key event stream handshake between the key scheduler and its consumer.
// Ports (signals):
//   evt_valid  source -> sink  head of the event FIFO is valid
//   evt_ready  sink -> source  sink accepts the head this cycle
//   evt_key    source -> sink  key index of the head event
//   evt_long   source -> sink  1 = LONG press, 0 = SHORT press
interface key_event_if #(
  parameter int unsigned IDX_W = 3
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_key;
  logic             evt_long;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_long,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_long,
    output evt_ready
  );
endinterface

// File: rtl/key_event_scheduler.sv
// Per-key SHORT/LONG press classifier feeding a shared, round-robin arbitrated
// event FIFO with a valid/ready output stream.
// Ports:
//   clk_100Hz  100 Hz tick clock
//   rst_n      asynchronous active-low reset
//   key_in     debounced key levels, 1 = pressed
//   evt        event stream (master side of key_event_if)
//   overflow   1-cycle pulse when a request is dropped (key already pending)
//   busy       any pending request or FIFO not empty
module key_event_scheduler #(
  parameter int unsigned N_KEYS     = 5,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned LONG_TICKS = 100,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_100Hz,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  key_event_if.master       evt,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(LONG_TICKS + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    KEY_IDLE      = 2'd0,
    KEY_PRESSED   = 2'd1,
    KEY_LONG_HELD = 2'd2
  } key_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] key;
    logic             is_long;
  } evt_entry_t;

  logic [N_KEYS-1:0] key_dly;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;

  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] req;
  logic [N_KEYS-1:0] req_long;

  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] pend_long_q, pend_long_d;
  logic [N_KEYS-1:0] drop;

  logic [IDX_W-1:0]  rr_ptr;
  logic              grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [N_KEYS-1:0] grant_vec;

  evt_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              pop, full, can_push;
  evt_entry_t        push_entry;
  evt_entry_t        head_d;

  assign press = ~key_dly & key_in;
  assign rel   = key_dly & ~key_in;

  // Key level history for edge detection
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) key_dly <= '0;
    else        key_dly <= key_in;
  end

  // Per-key FSM state register
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state_q[i] <= KEY_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-key FSM next state; cnt counts high samples and saturates at LONG_TICKS
  always_comb begin
    for (int i = 0; i < int'(N_KEYS); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        KEY_IDLE: begin
          if (press[i]) begin
            state_d[i] = KEY_PRESSED;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        KEY_PRESSED: begin
          if (rel[i]) begin
            state_d[i] = KEY_IDLE;
            cnt_d[i]   = '0;
          end else if (key_in[i]) begin
            if (cnt_q[i] == CNT_W'(LONG_TICKS - 1)) begin
              state_d[i] = KEY_LONG_HELD;
              cnt_d[i]   = CNT_W'(LONG_TICKS);
            end else if (cnt_q[i] < CNT_W'(LONG_TICKS)) begin
              cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
            end
          end
        end
        KEY_LONG_HELD: begin
          if (rel[i]) begin
            state_d[i] = KEY_IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = KEY_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Per-key FSM outputs: SHORT on release while PRESSED, LONG on the LONG_TICKS-th sample
  always_comb begin
    req      = '0;
    req_long = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (state_q[i] == KEY_PRESSED) begin
        if (rel[i]) begin
          req[i] = 1'b1;
        end else if (key_in[i] && (cnt_q[i] == CNT_W'(LONG_TICKS - 1))) begin
          req[i]      = 1'b1;
          req_long[i] = 1'b1;
        end
      end
    end
  end

  assign pop      = evt.evt_valid & evt.evt_ready;
  assign full     = (fcnt_q == FCNT_W'(FIFO_DEPTH));
  assign can_push = ~full | pop;

  // Round-robin grant: first pending key scanning cyclically from rr_ptr
  always_comb begin
    int unsigned scan;
    scan      = 0;
    grant     = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (can_push) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        scan = (32'(rr_ptr) + k) % N_KEYS;
        if (!grant && pending_q[scan]) begin
          grant           = 1'b1;
          grant_idx       = IDX_W'(scan);
          grant_vec[scan] = 1'b1;
        end
      end
    end
  end

  // Pending bookkeeping: a same-edge grant frees the slot, so set wins over clear
  always_comb begin
    pending_d   = pending_q & ~grant_vec;
    pend_long_d = pend_long_q;
    drop        = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (req[i]) begin
        if (pending_d[i]) begin
          drop[i] = 1'b1;
        end else begin
          pending_d[i]   = 1'b1;
          pend_long_d[i] = req_long[i];
        end
      end
    end
  end

  assign push_entry = '{key: grant_idx, is_long: pend_long_q[grant_idx]};

  // FIFO occupancy after this edge
  always_comb begin
    fcnt_d = fcnt_q;
    if (grant && !pop)      fcnt_d = FCNT_W'(fcnt_q + FCNT_W'(1));
    else if (!grant && pop) fcnt_d = FCNT_W'(fcnt_q - FCNT_W'(1));
  end

  // Head entry after this edge, so the output registers track the FIFO head
  always_comb begin
    head_d = '0;
    if (fcnt_d != '0) begin
      if ((fcnt_q == '0) || ((fcnt_q == FCNT_W'(1)) && pop)) head_d = push_entry;
      else if (pop)                                          head_d = mem[PTR_W'(rd_ptr + PTR_W'(1))];
      else                                                   head_d = mem[rd_ptr];
    end
  end

  // Event FIFO storage
  always_ff @(posedge clk_100Hz) begin
    if (grant) mem[wr_ptr] <= push_entry;
  end

  // Control registers and registered outputs
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      pend_long_q   <= '0;
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcnt_q        <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      evt.evt_long  <= 1'b0;
      overflow      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_long_q <= pend_long_d;
      fcnt_q      <= fcnt_d;
      if (grant) begin
        wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
        rr_ptr <= (grant_idx == IDX_W'(N_KEYS - 1)) ? '0 : IDX_W'(grant_idx + IDX_W'(1));
      end
      if (pop) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      evt.evt_valid <= (fcnt_d != '0);
      evt.evt_key   <= head_d.key;
      evt.evt_long  <= head_d.is_long;
      overflow      <= |drop;
      busy          <= (|pending_d) | (fcnt_d != '0);
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;
  localparam int N  = 5;
  localparam int IW = 3;
  localparam int LT = 100;
  localparam int FD = 4;

  typedef struct packed {
    logic [IW-1:0] key;
    logic          lng;
  } ev_t;

  logic         clk_100Hz = 1'b0;
  logic         rst_n     = 1'b0;
  logic [N-1:0] key_in    = '0;
  logic         overflow;
  logic         busy;

  key_event_if #(.IDX_W(IW)) evt ();

  key_event_scheduler #(
    .N_KEYS(N), .IDX_W(IW), .LONG_TICKS(LT), .FIFO_DEPTH(FD)
  ) dut (
    .clk_100Hz (clk_100Hz),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .evt       (evt),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  // Reference model state: consecutive-high sample counts, pending slots, FIFO fill
  int  hold  [N];
  bit  pend  [N];
  bit  plong [N];
  int  rr;
  int  fcnt;
  bit  exp_ovf;
  bit  exp_busy;
  ev_t exp_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hold[i]  = 0;
      pend[i]  = 1'b0;
      plong[i] = 1'b0;
    end
    rr       = 0;
    fcnt     = 0;
    exp_ovf  = 1'b0;
    exp_busy = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit  pop;
    int  g;
    int  idx;
    bit  rq;
    bit  lg;
    ev_t e;
    pop = (fcnt > 0) && evt.evt_ready;
    g   = -1;
    if ((fcnt < FD) || pop) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      e.key = IW'(g);
      e.lng = plong[g];
      exp_q.push_back(e);
      pend[g] = 1'b0;
      rr      = (g + 1) % N;
      fcnt++;
    end
    if (pop) fcnt--;
    exp_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq = 1'b0;
      lg = 1'b0;
      if (key_in[i]) begin
        if (hold[i] <= LT) hold[i]++;
        if (hold[i] == LT) begin
          rq = 1'b1;
          lg = 1'b1;
        end
      end else begin
        if (hold[i] > 0 && hold[i] < LT) rq = 1'b1;
        hold[i] = 0;
      end
      if (rq) begin
        if (pend[i]) begin
          exp_ovf = 1'b1;
        end else begin
          pend[i]  = 1'b1;
          plong[i] = lg;
        end
      end
    end
    exp_busy = (fcnt > 0);
    for (int i = 0; i < N; i++) if (pend[i]) exp_busy = 1'b1;
  endtask

  // Model advances on the same edges as the DUT
  initial begin
    model_reset();
    forever begin
      @(posedge clk_100Hz or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: compares outputs mid-cycle and consumes the scoreboard on handshakes
  initial begin
    forever begin
      @(negedge clk_100Hz);
      if (!rst_n) begin
        chk("reset_outputs", int'({evt.evt_valid, evt.evt_key, evt.evt_long, overflow, busy}), 0);
      end else begin
        chk("evt_valid", int'(evt.evt_valid), int'(fcnt > 0));
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("busy", int'(busy), int'(exp_busy));
        if (evt.evt_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            chk("evt_key", int'(evt.evt_key), int'(exp_q[0].key));
            chk("evt_long", int'(evt.evt_long), int'(exp_q[0].lng));
            if (evt.evt_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100Hz);
    #2;
  endtask

  task automatic tap(input int k, input int len);
    key_in[k] = 1'b1;
    cyc(len);
    key_in[k] = 1'b0;
    cyc(2);
  endtask

  initial begin
    evt.evt_ready = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Single SHORT press on key 2
    evt.evt_ready = 1'b1;
    key_in[2] = 1'b1;
    cyc(10);
    key_in[2] = 1'b0;
    cyc(6);

    // LONG press on key 0, no event on release
    key_in[0] = 1'b1;
    cyc(150);
    key_in[0] = 1'b0;
    cyc(5);

    // Simultaneous releases from rr_ptr = 0, then wrap-around order
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    key_in[1] = 1'b1; key_in[3] = 1'b1;
    cyc(5);
    key_in[1] = 1'b0; key_in[3] = 1'b0;
    cyc(6);
    key_in[0] = 1'b1; key_in[4] = 1'b1;
    cyc(5);
    key_in[0] = 1'b0; key_in[4] = 1'b0;
    cyc(6);

    // Backpressure: FIFO fills, fifth request waits pending
    evt.evt_ready = 1'b0;
    for (int k = 0; k < N; k++) tap(k, 3);
    cyc(3);
    evt.evt_ready = 1'b1;
    cyc(10);

    // Overflow: key 1 re-requests while still pending behind a full FIFO
    evt.evt_ready = 1'b0;
    tap(0, 3); tap(2, 3); tap(3, 3); tap(4, 3);
    tap(1, 3);
    tap(1, 4);
    cyc(3);
    evt.evt_ready = 1'b1;
    cyc(12);

    // Reset during a hold; key still high afterwards counts as a fresh press
    key_in[3] = 1'b1;
    cyc(60);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(120);
    key_in[3] = 1'b0;
    cyc(5);

    // Random: fast toggling with random backpressure
    repeat (2500) begin
      for (int k = 0; k < N; k++) if ($urandom_range(7) == 0) key_in[k] = ~key_in[k];
      evt.evt_ready = ($urandom_range(3) != 0);
      cyc(1);
    end

    // Random: slow toggling so LONG presses occur
    repeat (3000) begin
      for (int k = 0; k < N; k++) if ($urandom_range(79) == 0) key_in[k] = ~key_in[k];
      evt.evt_ready = ($urandom_range(1) != 0);
      cyc(1);
    end

    key_in = '0;
    evt.evt_ready = 1'b1;
    cyc(20);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
